// File: rtl/seq_pkg.sv
// Shared types and default beat counts for the conv1 -> maxpool -> fire layer sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV1 = 3'd1,
        ST_POOL1 = 3'd2,
        ST_FIRE  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    localparam int CONV1_OUTS_DEF = 12321;
    localparam int POOL1_OUTS_DEF = 3025;
    localparam int SQ_OUTS_DEF    = 3025;
    localparam int NUM_FIRES_MAX  = 8;

endpackage

// File: rtl/beat_counter.sv
// Per-stage output beat counter; saturates at limit and flags the final beat.
module beat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         last_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;

    assign count_o = count_q;
    assign last_o  = inc_i && (count_q == (limit_i - ONE));

    // Beat count register, cleared on request, never advancing past limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= {W{1'b0}};
        end else if (clr_i) begin
            count_q <= {W{1'b0}};
        end else if (inc_i && (count_q != limit_i)) begin
            count_q <= count_q + ONE;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Sequences conv1 -> maxpool2d -> squeeze1x1 fires: stage enables, bank write addresses,
// fire select and ping-pong bank, with sticky detection of valids from inactive stages.
module layer_sequencer
    import seq_pkg::*;
#(
    parameter int CONV1_OUTS = CONV1_OUTS_DEF,
    parameter int POOL1_OUTS = POOL1_OUTS_DEF,
    parameter int SQ_OUTS    = SQ_OUTS_DEF,
    parameter int NUM_FIRES  = NUM_FIRES_MAX,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              conv1_valid,
    input  logic              pool_valid,
    input  logic              sq_valid,
    output logic              conv_en,
    output logic              pool_en,
    output logic              sq_en,
    output logic [ADDR_W-1:0] conv_wr_addr,
    output logic [ADDR_W-1:0] pool_wr_addr,
    output logic [ADDR_W-1:0] sq_wr_addr,
    output logic [2:0]        firesel,
    output logic              pp_bank,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] CONV_LIM  = ADDR_W'(CONV1_OUTS);
    localparam logic [ADDR_W-1:0] POOL_LIM  = ADDR_W'(POOL1_OUTS);
    localparam logic [ADDR_W-1:0] SQ_LIM    = ADDR_W'(SQ_OUTS);
    localparam logic [2:0]        LAST_FIRE = 3'(NUM_FIRES - 1);

    seq_state_e state_q, state_d;
    logic       conv_en_q, pool_en_q, sq_en_q, busy_q, done_q;
    logic       err_q, err_d, pp_bank_q, pp_bank_d;
    logic [2:0] firesel_q, firesel_d;
    logic       start_acc_s, stray_s, clr_all_s, clr_sq_s;
    logic       conv_inc_s, pool_inc_s, sq_inc_s;
    logic       conv_last_s, pool_last_s, sq_last_s;

    // A beat counts only for the active stage, and abort freezes every counter.
    assign conv_inc_s  = conv1_valid && (state_q == ST_CONV1) && !abort;
    assign pool_inc_s  = pool_valid  && (state_q == ST_POOL1) && !abort;
    assign sq_inc_s    = sq_valid    && (state_q == ST_FIRE)  && !abort;
    assign start_acc_s = start && (state_q == ST_IDLE) && !abort;
    assign stray_s     = (conv1_valid && (state_q != ST_CONV1))
                       | (pool_valid  && (state_q != ST_POOL1))
                       | (sq_valid    && (state_q != ST_FIRE));

    beat_counter #(.W(ADDR_W)) u_conv_cnt (
        .clk(clk), .rst(rst), .clr_i(clr_all_s), .inc_i(conv_inc_s),
        .limit_i(CONV_LIM), .count_o(conv_wr_addr), .last_o(conv_last_s)
    );

    beat_counter #(.W(ADDR_W)) u_pool_cnt (
        .clk(clk), .rst(rst), .clr_i(clr_all_s), .inc_i(pool_inc_s),
        .limit_i(POOL_LIM), .count_o(pool_wr_addr), .last_o(pool_last_s)
    );

    beat_counter #(.W(ADDR_W)) u_sq_cnt (
        .clk(clk), .rst(rst), .clr_i(clr_all_s | clr_sq_s), .inc_i(sq_inc_s),
        .limit_i(SQ_LIM), .count_o(sq_wr_addr), .last_o(sq_last_s)
    );

    // Next-state, fire/bank bookkeeping and counter clears.
    always_comb begin
        state_d   = state_q;
        firesel_d = firesel_q;
        pp_bank_d = pp_bank_q;
        clr_all_s = 1'b0;
        clr_sq_s  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        state_d   = ST_CONV1;
                        clr_all_s = 1'b1;
                        firesel_d = 3'd0;
                        pp_bank_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CONV1: begin
                    if (conv_last_s) state_d = ST_POOL1;
                    else             state_d = ST_CONV1;
                end
                ST_POOL1: begin
                    if (pool_last_s) begin
                        state_d   = ST_GAP;
                        firesel_d = 3'd0;
                        pp_bank_d = 1'b0;
                    end else begin
                        state_d = ST_POOL1;
                    end
                end
                ST_GAP: begin
                    state_d  = ST_FIRE;
                    clr_sq_s = 1'b1;
                end
                ST_FIRE: begin
                    if (sq_last_s && (firesel_q < LAST_FIRE)) begin
                        state_d   = ST_GAP;
                        firesel_d = firesel_q + 3'd1;
                        pp_bank_d = ~pp_bank_q;
                    end else if (sq_last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FIRE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        err_d = (start_acc_s ? 1'b0 : err_q) | stray_s;
    end

    // State and registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            conv_en_q <= 1'b0;
            pool_en_q <= 1'b0;
            sq_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            firesel_q <= 3'd0;
            pp_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            conv_en_q <= (state_d == ST_CONV1);
            pool_en_q <= (state_d == ST_POOL1);
            sq_en_q   <= (state_d == ST_FIRE);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            err_q     <= err_d;
            firesel_q <= firesel_d;
            pp_bank_q <= pp_bank_d;
        end
    end

    assign conv_en = conv_en_q;
    assign pool_en = pool_en_q;
    assign sq_en   = sq_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign firesel = firesel_q;
    assign pp_bank = pp_bank_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench: full-size instance for the complete run and transfer edge, small
// instance for bursty traffic, stray valids, abort, busy start and mid-fire reset.
module tb_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance (NUM_FIRES=2)
    logic rst, start, abort, cv, pv, sv;
    logic conv_en, pool_en, sq_en, pp_bank, busy, done, err;
    logic [31:0] conv_a, pool_a, sq_a;
    logic [2:0]  firesel;

    layer_sequencer #(.CONV1_OUTS(12321), .POOL1_OUTS(3025), .SQ_OUTS(3025),
                      .NUM_FIRES(2), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .conv1_valid(cv), .pool_valid(pv), .sq_valid(sv),
        .conv_en(conv_en), .pool_en(pool_en), .sq_en(sq_en),
        .conv_wr_addr(conv_a), .pool_wr_addr(pool_a), .sq_wr_addr(sq_a),
        .firesel(firesel), .pp_bank(pp_bank), .busy(busy), .done(done), .err(err)
    );

    // Small instance: 121 conv, 25 pool, 200 squeeze beats, 4 fires
    logic rst_s, start_s, abort_s, cv_s, pv_s, sv_s;
    logic conv_en_s, pool_en_s, sq_en_s, pp_bank_s, busy_s, done_s, err_s;
    logic [31:0] conv_a_s, pool_a_s, sq_a_s;
    logic [2:0]  firesel_s;

    layer_sequencer #(.CONV1_OUTS(121), .POOL1_OUTS(25), .SQ_OUTS(200),
                      .NUM_FIRES(4), .ADDR_W(32)) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s), .abort(abort_s),
        .conv1_valid(cv_s), .pool_valid(pv_s), .sq_valid(sv_s),
        .conv_en(conv_en_s), .pool_en(pool_en_s), .sq_en(sq_en_s),
        .conv_wr_addr(conv_a_s), .pool_wr_addr(pool_a_s), .sq_wr_addr(sq_a_s),
        .firesel(firesel_s), .pp_bank(pp_bank_s), .busy(busy_s), .done(done_s), .err(err_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int n_conv, n_pool, n_sq, n_gap, n_done, n_fires, n_beats, n_err;
    logic [2:0] fs_rec [4];
    logic       pp_rec [4];
    logic       conv_pend, sq_prev;

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; cv = 1'b0; pv = 1'b0; sv = 1'b0;
        rst_s = 1'b0; start_s = 1'b0; abort_s = 1'b0; cv_s = 1'b0; pv_s = 1'b0; sv_s = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_flags", {conv_en, pool_en, sq_en, firesel, pp_bank, busy, done, err}, 64'd0);
        chk("reset_addrs", conv_a | pool_a | sq_a, 64'd0);
        rst = 1'b1; rst_s = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {busy, conv_en}, 64'd0);

        // Full run, continuous valids
        n_conv = 0; n_pool = 0; n_sq = 0; n_gap = 0; n_done = 0; n_fires = 0;
        conv_pend = 1'b0; sq_prev = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_conv_en", {busy, conv_en, pool_en}, 64'd6);
        chk("start_conv_addr", conv_a, 64'd0);
        for (int i = 0; i < 25000; i++) begin
            if (conv_en) n_conv++;
            if (pool_en) n_pool++;
            if (sq_en)   n_sq++;
            if (done)    n_done++;
            if (busy && !conv_en && !pool_en && !sq_en && !done) n_gap++;
            if (conv_pend) begin
                chk("xfer_conv_en", conv_en, 64'd0);
                chk("xfer_pool_en", pool_en, 64'd1);
                chk("xfer_conv_addr", conv_a, 64'd12321);
                conv_pend = 1'b0;
            end
            if (conv_en && conv_a == 32'd12320) conv_pend = 1'b1;
            if (sq_en && !sq_prev) begin
                chk("fire_start_addr", sq_a, 64'd0);
                if (n_fires < 4) begin
                    fs_rec[n_fires] = firesel;
                    pp_rec[n_fires] = pp_bank;
                end
                n_fires++;
            end
            sq_prev = sq_en;
            cv = conv_en; pv = pool_en; sv = sq_en;
            if (!busy) break;
            @(negedge clk);
        end
        chk("run_finished", busy, 64'd0);
        chk("conv_en_beats", n_conv, 64'd12321);
        chk("pool_en_beats", n_pool, 64'd3025);
        chk("sq_en_beats", n_sq, 64'd6050);
        chk("gap_cycles", n_gap, 64'd2);
        chk("done_pulses", n_done, 64'd1);
        chk("fire_count", n_fires, 64'd2);
        chk("fire0_sel_pp", {fs_rec[0], pp_rec[0]}, 64'd0);
        chk("fire1_sel_pp", {fs_rec[1], pp_rec[1]}, 64'd3);
        chk("hold_sel_pp", {firesel, pp_bank}, 64'd3);
        chk("hold_addrs", {conv_a, sq_a}, {32'd12321, 32'd3025});
        chk("hold_pool_addr", pool_a, 64'd3025);
        chk("run_no_err", err, 64'd0);

        // Bursty valids at ~30% duty on the small instance
        n_done = 0; n_fires = 0; n_beats = 0; n_err = 0; sq_prev = 1'b0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (done_s) n_done++;
            if (err_s)  n_err++;
            if (sq_en_s && !sq_prev) n_fires++;
            sq_prev = sq_en_s;
            cv_s = conv_en_s && ($urandom_range(0, 99) < 30);
            pv_s = pool_en_s && ($urandom_range(0, 99) < 30);
            sv_s = sq_en_s   && ($urandom_range(0, 99) < 30);
            if (cv_s || pv_s || sv_s) n_beats++;
            if (!busy_s) break;
            @(negedge clk);
        end
        chk("burst_finished", busy_s, 64'd0);
        chk("burst_beats", n_beats, 64'd946);
        chk("burst_addrs", {conv_a_s, pool_a_s}, {32'd121, 32'd25});
        chk("burst_sq_addr", sq_a_s, 64'd200);
        chk("burst_sel_pp", {firesel_s, pp_bank_s}, 64'd7);
        chk("burst_fires", n_fires, 64'd4);
        chk("burst_done", n_done, 64'd1);
        chk("burst_no_err", n_err, 64'd0);

        // Stray conv1 beat during POOL1, busy start, abort on the last pool beat
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 0; i < 5000 && !(pool_en_s && pool_a_s == 32'd5); i++) begin
            cv_s = conv_en_s; pv_s = pool_en_s; sv_s = sq_en_s;
            @(negedge clk);
        end
        cv_s = 1'b1; pv_s = 1'b0; sv_s = 1'b0;
        chk("reach_pool5", pool_a_s, 64'd5);
        @(negedge clk);
        cv_s = 1'b0;
        chk("stray_pool_addr", pool_a_s, 64'd5);
        chk("stray_conv_addr", conv_a_s, 64'd121);
        chk("stray_err", {err_s, pool_en_s}, 64'd3);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("busy_start_ignored", {err_s, pool_en_s, pool_a_s}, {2'b11, 32'd5});
        for (int i = 0; i < 5000 && !(pool_en_s && pool_a_s == 32'd24); i++) begin
            pv_s = pool_en_s;
            @(negedge clk);
        end
        chk("reach_pool24", pool_a_s, 64'd24);
        abort_s = 1'b1; pv_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0; pv_s = 1'b0;
        chk("abort_idle", {busy_s, conv_en_s, pool_en_s, sq_en_s, done_s}, 64'd0);
        chk("abort_hold_addr", pool_a_s, 64'd24);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_s) n_done++;
        end
        chk("abort_no_done", {n_done[7:0], err_s}, 64'd1);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("restart_clears", {err_s, conv_a_s, pool_a_s}, 64'd0);
        chk("restart_conv_en", {busy_s, conv_en_s}, 64'd3);

        // start during CONV1 is ignored
        cv_s = 1'b1;
        repeat (3) @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("conv_start_ignored", {err_s, conv_en_s, conv_a_s}, {2'b01, 32'd4});

        // Reset while firesel=3, sq_wr_addr=100
        for (int i = 0; i < 5000 && !(sq_en_s && firesel_s == 3'd3 && sq_a_s == 32'd100); i++) begin
            cv_s = conv_en_s; pv_s = pool_en_s; sv_s = sq_en_s;
            @(negedge clk);
        end
        chk("reach_fire3", {firesel_s, pp_bank_s, sq_a_s}, {4'b0111, 32'd100});
        cv_s = 1'b0; pv_s = 1'b0; sv_s = 1'b0;
        rst_s = 1'b0;
        #1;
        chk("midfire_rst_flags",
            {conv_en_s, pool_en_s, sq_en_s, firesel_s, pp_bank_s, busy_s, done_s, err_s}, 64'd0);
        chk("midfire_rst_addrs", conv_a_s | pool_a_s | sq_a_s, 64'd0);
        @(negedge clk);
        rst_s = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {busy_s, conv_en_s, sq_en_s, err_s}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
